// File: rtl/aes_key_schedule_if.sv
// rtl/aes_key_schedule_if.sv - key/round-key handshake bundle for aes_key_schedule
interface aes_key_schedule_if;
  logic         key_valid_i;
  logic         key_ready_o;
  logic [127:0] key_i;
  logic         decrypt_i;
  logic         rk_valid_o;
  logic         rk_ready_i;
  logic [127:0] rk_o;
  logic [3:0]   rk_idx_o;
  logic         rk_last_o;
  logic         busy_o;

  // Key schedule side
  modport slave (
    input  key_valid_i, key_i, decrypt_i, rk_ready_i,
    output key_ready_o, rk_valid_o, rk_o, rk_idx_o, rk_last_o, busy_o
  );

  // Key source / round-key consumer side
  modport master (
    output key_valid_i, key_i, decrypt_i, rk_ready_i,
    input  key_ready_o, rk_valid_o, rk_o, rk_idx_o, rk_last_o, busy_o
  );
endinterface

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - AES-128 round-key generator, forward or reverse order; optional AES_KS_ZEROIZE_EN
module aes_key_schedule #(
  parameter int NR = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  aes_key_schedule_if.slave    bus
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_key_schedule: only NR=10 (AES-128) is supported");
  end

  typedef enum logic [1:0] {IDLE, PREP, EMIT} state_t;

  // Forward AES S-box, byte 0x00 in the top byte of the first row
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // byte b sits at bit 2047-8*b, which is {~b, 3'b111}
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_t         state;
  state_t         state_next;
  logic [127:0]   w;
  logic [3:0]     idx;
  logic           dec;

  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    i1, i2, i3;
  logic [31:0]    f0, f1, f2, f3;
  logic [31:0]    sb_in, t;
  logic [3:0]     rc_idx;
  logic           use_inv;
  logic [127:0]   step;
  logic           key_fire;
  logic           rk_fire;
  logic           last;

  assign {w0, w1, w2, w3} = w;

  // The inverse step recovers the previous w3 first, then recomputes the same t
  // the forward step used, so one S-box serves both directions.
  assign use_inv = (state == EMIT) && dec;
  assign i3      = w3 ^ w2;
  assign i2      = w2 ^ w1;
  assign i1      = w1 ^ w0;
  assign sb_in   = use_inv ? i3 : w3;
  assign rc_idx  = use_inv ? idx - 4'd1 : idx;
  assign t       = sub_word({sb_in[23:0], sb_in[31:24]}) ^ {rcon(rc_idx), 24'h0};

  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  assign step = use_inv ? {w0 ^ t, i1, i2, i3} : {f0, f1, f2, f3};

  assign key_fire = bus.key_valid_i && (state == IDLE);
  assign rk_fire  = (state == EMIT) && bus.rk_ready_i;
  assign last     = (state == EMIT) && (dec ? (idx == 4'd0) : (idx == 4'd10));

  assign bus.key_ready_o = (state == IDLE);
  assign bus.busy_o      = (state != IDLE);
  assign bus.rk_valid_o  = (state == EMIT);
  assign bus.rk_idx_o    = idx;
  assign bus.rk_last_o   = last;
`ifdef AES_KS_ZEROIZE_EN
  assign bus.rk_o        = (state == EMIT) ? w : 128'h0;
`else
  assign bus.rk_o        = w;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (key_fire) state_next = bus.decrypt_i ? PREP : EMIT;
      PREP: if (idx == 4'd9) state_next = EMIT;
      EMIT: if (rk_fire && last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Key state, round index and direction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w   <= 128'h0;
      idx <= 4'd0;
      dec <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_fire) begin
            w   <= bus.key_i;
            dec <= bus.decrypt_i;
            idx <= 4'd0;
          end
        end
        PREP: begin
          w   <= step;
          idx <= idx + 4'd1;
        end
        EMIT: begin
          if (rk_fire) begin
            if (last) begin
`ifdef AES_KS_ZEROIZE_EN
              w <= 128'h0;
`endif
            end else begin
              w   <= step;
              idx <= dec ? idx - 4'd1 : idx + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - directed bench for aes_key_schedule (FIPS-197 and all-zero keys)
module tb_aes_key_schedule;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  aes_key_schedule_if bus();

  aes_key_schedule #(.NR(10)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_Z  = 128'h0;
  localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [127:0] rk_a [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_key(input string tag, input int i, input logic [127:0] exp, input logic exp_last);
    chk({tag, "_valid"}, 128'(bus.rk_valid_o), 128'd1);
    chk({tag, "_rk"},    bus.rk_o, exp);
    chk({tag, "_idx"},   128'(bus.rk_idx_o), 128'(i));
    chk({tag, "_last"},  128'(bus.rk_last_o), 128'(exp_last));
  endtask

  initial begin
    logic         ready;
    logic         stalled;
    logic         done;
    logic [127:0] prev_rk;
    logic [3:0]   prev_idx;
    logic         prev_last;
    int           exp_i;
    int           cyc;

    bus.key_valid_i = 1'b0;
    bus.key_i       = '0;
    bus.decrypt_i   = 1'b0;
    bus.rk_ready_i  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_key_ready", 128'(bus.key_ready_o), 128'd1);
    chk("rst_rk_valid",  128'(bus.rk_valid_o),  128'd0);
    chk("rst_rk",        bus.rk_o,              128'd0);
    chk("rst_idx",       128'(bus.rk_idx_o),    128'd0);
    chk("rst_last",      128'(bus.rk_last_o),   128'd0);
    chk("rst_busy",      128'(bus.busy_o),      128'd0);
    rst_i = 1'b0;

    // Encrypt at full rate
    bus.key_i = KEY_A; bus.decrypt_i = 1'b0; bus.key_valid_i = 1'b1; bus.rk_ready_i = 1'b1;
    @(negedge clk);
    bus.key_valid_i = 1'b0;
    chk_key("enc0", 0, rk_a[0], 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk_key($sformatf("enc%0d", i), i, rk_a[i], i == 10);
    end
    @(negedge clk);
    chk("enc_end_key_ready", 128'(bus.key_ready_o), 128'd1);
    chk("enc_end_rk_valid",  128'(bus.rk_valid_o),  128'd0);

    // Decrypt at full rate
    bus.key_i = KEY_A; bus.decrypt_i = 1'b1; bus.key_valid_i = 1'b1;
    @(negedge clk);
    bus.key_valid_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("dec_prep%0d_valid", c), 128'(bus.rk_valid_o), 128'd0);
      @(negedge clk);
    end
    for (int i = 10; i >= 0; i--) begin
      chk_key($sformatf("dec%0d", i), i, rk_a[i], i == 0);
      if (i > 0) @(negedge clk);
    end
    @(negedge clk);
    chk("dec_end_key_ready", 128'(bus.key_ready_o), 128'd1);

    // Encrypt with backpressure
    bus.key_i = KEY_A; bus.decrypt_i = 1'b0; bus.key_valid_i = 1'b1; bus.rk_ready_i = 1'b0;
    @(negedge clk);
    bus.key_valid_i = 1'b0;
    exp_i = 0; stalled = 1'b0; done = 1'b0; cyc = 0;
    prev_rk = '0; prev_idx = '0; prev_last = 1'b0;
    while (!done && cyc < 200) begin
      if (stalled) begin
        chk("bp_hold_rk",   bus.rk_o,               prev_rk);
        chk("bp_hold_idx",  128'(bus.rk_idx_o),     128'(prev_idx));
        chk("bp_hold_last", 128'(bus.rk_last_o),    128'(prev_last));
      end
      ready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.rk_ready_i = ready;
      if (ready) begin
        chk_key($sformatf("bp%0d", exp_i), exp_i, rk_a[exp_i], exp_i == 10);
        if (exp_i == 10) done = 1'b1;
        exp_i++;
      end
      stalled   = !ready;
      prev_rk   = bus.rk_o;
      prev_idx  = bus.rk_idx_o;
      prev_last = bus.rk_last_o;
      cyc++;
      @(negedge clk);
    end
    chk("bp_complete", 128'(done), 128'd1);
    chk("bp_end_key_ready", 128'(bus.key_ready_o), 128'd1);

    // Reset in the middle of PREP
    bus.rk_ready_i = 1'b1;
    bus.key_i = KEY_A; bus.decrypt_i = 1'b1; bus.key_valid_i = 1'b1;
    @(negedge clk);
    bus.key_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_prep_busy", 128'(bus.busy_o), 128'd1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("mrst_rk_valid",  128'(bus.rk_valid_o),  128'd0);
    chk("mrst_busy",      128'(bus.busy_o),      128'd0);
    chk("mrst_key_ready", 128'(bus.key_ready_o), 128'd1);
    chk("mrst_idx",       128'(bus.rk_idx_o),    128'd0);
    rst_i = 1'b0;
    bus.key_i = KEY_A; bus.decrypt_i = 1'b0; bus.key_valid_i = 1'b1;
    @(negedge clk);
    bus.key_valid_i = 1'b0;
    chk_key("mrst_enc0", 0, rk_a[0], 1'b0);
    @(negedge clk);
    chk_key("mrst_enc1", 1, rk_a[1], 1'b0);
    cyc = 0;
    while (!bus.key_ready_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("mrst_drain", 128'(bus.key_ready_o), 128'd1);

    // New key offered while busy, then back-to-back decrypt
    bus.key_i = KEY_A; bus.decrypt_i = 1'b0; bus.key_valid_i = 1'b1;
    @(negedge clk);
    bus.key_i = KEY_Z; bus.decrypt_i = 1'b1;
    chk_key("busy0", 0, rk_a[0], 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk_key($sformatf("busy%0d", i), i, rk_a[i], i == 10);
    end
    @(negedge clk);
    chk("b2b_key_ready", 128'(bus.key_ready_o), 128'd1);
`ifdef AES_KS_ZEROIZE_EN
    chk("b2b_idle_rk_zero", bus.rk_o, 128'd0);
`endif
    @(negedge clk);
    bus.key_valid_i = 1'b0;
    chk("b2b_accepted_busy", 128'(bus.busy_o),      128'd1);
    chk("b2b_key_ready_low", 128'(bus.key_ready_o), 128'd0);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("b2b_prep%0d_valid", c), 128'(bus.rk_valid_o), 128'd0);
`ifdef AES_KS_ZEROIZE_EN
      chk($sformatf("b2b_prep%0d_rk_zero", c), bus.rk_o, 128'd0);
`endif
      @(negedge clk);
    end
    for (int i = 10; i >= 0; i--) begin
      chk($sformatf("zdec%0d_idx", i),  128'(bus.rk_idx_o),  128'(i));
      chk($sformatf("zdec%0d_last", i), 128'(bus.rk_last_o), 128'(i == 0));
      if (i == 10) chk("zdec10_rk", bus.rk_o, Z_RK10);
      if (i == 1)  chk("zdec1_rk",  bus.rk_o, Z_RK1);
      if (i == 0)  chk("zdec0_rk",  bus.rk_o, KEY_Z);
      if (i > 0) @(negedge clk);
    end
    @(negedge clk);
    chk("final_key_ready", 128'(bus.key_ready_o), 128'd1);
    chk("final_busy",      128'(bus.busy_o),      128'd0);
`ifdef AES_KS_ZEROIZE_EN
    chk("final_rk_zero", bus.rk_o, 128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
